// File: rtl/serial_full_subtractor_if.sv
`default_nettype none
// ============================================================================
//  serial_full_subtractor_if
//  Operand and result valid/ready handshakes of the bit-serial subtractor.
//  Revision: 1.0
// ============================================================================
interface serial_full_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] DIFF;
    logic             Bout;
    logic             busy;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, DIFF, Bout, busy
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, DIFF, Bout, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_full_subtractor.sv
`default_nettype none
// ============================================================================
//  serial_full_subtractor
//  LSB-first A - B - Bin using one full-subtractor cell and a borrow flop.
//  Revision: 1.0
// ============================================================================
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    serial_full_subtractor_if.slave bus
);
    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_d_sr;
    logic               r_br;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic               w_a;
    logic               w_b;
    logic               w_d;
    logic               w_bn;
    logic [WIDTH-1:0]   w_d_next;

    // Full-subtractor cell on the current LSBs and the running borrow.
    assign w_a      = r_a_sr[0];
    assign w_b      = r_b_sr[0];
    assign w_d      = w_a ^ w_b ^ r_br;
    assign w_bn     = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
    assign w_d_next = {w_d, r_d_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_d_sr      <= '0;
            r_br        <= 1'b0;
            r_cnt       <= '0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.in_valid) begin
                        r_a_sr     <= bus.A;
                        r_b_sr     <= bus.B;
                        r_br       <= bus.Bin;
                        r_d_sr     <= '0;
                        r_cnt      <= '0;
                        r_state    <= c_busy;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                c_busy: begin
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_d_sr <= w_d_next;
                    r_br   <= w_bn;
                    if (r_cnt == c_last) begin
                        // Counter returns to 0 rather than stepping past WIDTH-1.
                        r_cnt       <= '0;
                        r_diff      <= w_d_next;
                        r_bout      <= w_bn;
                        r_state     <= c_done;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_done: begin
                    if (bus.out_ready) begin
                        r_state     <= c_idle;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_idle;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.DIFF      = r_diff;
    assign bus.Bout      = r_bout;
endmodule
`default_nettype wire
